add16_seq_ctrl: RTL
===================

// Module: add16_seq_ctrl
// PURPOSE
// - Sequencer driving one 16-bit ripple adder (module adder: x, y, cin -> sum, cout) over
//   multi-word operands, least-significant word first, with the carry registered between words.
// - Supports add and subtract (x - y as x + ~y + 1); streams result words out with valid/ready.
// - Sits between an operand source (register file / DMA) and a result sink for wide arithmetic.
// PARAMETERS
// - NWORDS  4  16-bit words per operand (legal 2..16)
// - CNT_W   $clog2(NWORDS)  word-counter width (derived, do not override)
// PORTS
// - clk         in   1   clock, all logic on rising edge
// - rst         in   1   synchronous reset, active-high
// - start       in   1   begin operation; accepted only when busy=0
// - sub         in   1   0=add, 1=subtract; sampled with accepted start
// - busy        out  1   operation in progress
// - in_valid    in   1   operand word pair valid
// - in_ready    out  1   sequencer can accept operand word pair
// - in_x        in   16  operand x word
// - in_y        in   16  operand y word
// - out_valid   out  1   result word valid
// - out_ready   in   1   sink accepts result word
// - out_sum     out  16  result word
// - out_last    out  1   out_sum is final (most-significant) word
// - done        out  1   1-cycle pulse when final result word is handshaken
// - cout_final  out  1   carry-out of final word (sub: 1 = no borrow); held until next start
// - ovf         out  1   signed overflow of full-width result; held until next start
// BEHAVIOUR
// - Reset: state IDLE; busy, in_ready, out_valid, out_last, done, cout_final, ovf = 0;
//   out_sum = 16'h0000; word counter = 0; carry reg = 0. Reset mid-operation discards all words.
// - FSM IDLE -> RUN on start&&!busy: latch sub, carry reg <= sub, counter <= 0,
//   clear cout_final/ovf. start while busy is ignored (no effect on anything).
// - RUN: in_ready = !out_valid || out_ready (1-deep output register).
//   Input handshake (in_valid&&in_ready): adder x=in_x, y=sub?~in_y:in_y, cin=carry reg;
//   next cycle out_sum<=sum, out_valid<=1, carry reg<=cout, counter++. Latency 1 cycle;
//   throughput 1 word/cycle while out_ready=1. Output handshake without new input clears out_valid.
// - Final word (counter==NWORDS-1 accepted): out_last<=1, cout_final<=cout,
//   ovf<=(x[15]==y'[15]) && (sum[15]!=x[15]) using y' = adder y input; FSM -> DRAIN, in_ready=0.
// - DRAIN: hold out_sum/out_last until out_ready; on that handshake done=1 for one cycle,
//   out_valid<=0, out_last<=0, busy<=0, FSM -> IDLE. Simultaneous start in that cycle ignored.
// - out_sum/out_last stable while out_valid&&!out_ready. in_ready=0 in IDLE and DRAIN.
// - Width: all arithmetic mod 2^16 per word; carry is the only inter-word state.
// CONFIGURATION
// - ADD16_SEQ_ZFLAG_EN defined: extra port zero_flag (out, 1) = 1 iff every result word was
//   16'h0000; valid from done pulse, held until next accepted start; reset value 0.
// - Not defined: port and zero-tracking logic absent; all other behaviour identical.
// TESTING (NWORDS=4, words listed LS first)
// - Reset: rst=1 two cycles -> busy=0, in_ready=0, out_valid=0, done=0, out_sum=0000.
// - Add: x={FFFF,0000,0000,0000}, y={0001,0000,0000,0000} -> out {0000,0001,0000,0000},
//   out_last on 4th, done 1 cycle, cout_final=0, ovf=0.
// - Sub: x={0001,0,0,0}, y={0002,0,0,0} -> out {FFFF,FFFF,FFFF,FFFF}, cout_final=0, ovf=0.
// - Overflow: x={FFFF,FFFF,FFFF,7FFF}, y={0001,0,0,0} -> out {0000,0000,0000,8000}, ovf=1, cout_final=0.
// - Backpressure: out_ready=0 for 3 cycles after word 0 -> in_ready=0, out_sum held,
//   all 4 words delivered in order; start pulsed while busy -> ignored.
// - Reset mid-op after 2 words -> IDLE next cycle, outputs at reset values; new add completes correctly.

Source files
------------

// File: rtl/add16_seq_ctrl.sv
// Multi-word add/subtract sequencer around a 16-bit ripple adder, LS word first.
// Optional zero_flag output is enabled by defining ADD16_SEQ_ZFLAG_EN.

module adder (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 16; gi++) begin : g_fa
    assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign cout = c[16];
endmodule

module add16_seq_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        done,
  output logic        cout_final,
  output logic        ovf
`ifdef ADD16_SEQ_ZFLAG_EN
  ,
  output logic        zero_flag
`endif
);
  localparam int CNT_W = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q;
  logic             carry_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [15:0]      out_sum_q;
  logic             done_q;
  logic             cout_final_q;
  logic             ovf_q;

  logic [15:0]      y_eff;
  logic [15:0]      sum_d;
  logic             cout_d;
  logic             in_hs;
  logic             out_hs;
  logic             ovf_d;

  // Subtraction inverts y and seeds the carry with 1 at start.
  assign y_eff = sub_q ? ~in_y : in_y;

  adder u_adder (
    .x    (in_x),
    .y    (y_eff),
    .cin  (carry_q),
    .sum  (sum_d),
    .cout (cout_d)
  );

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign ovf_d    = (in_x[15] == y_eff[15]) && (sum_d[15] != in_x[15]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sum_q    <= 16'h0000;
      done_q       <= 1'b0;
      cout_final_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RUN;
            busy_q       <= 1'b1;
            sub_q        <= sub;
            carry_q      <= sub;
            cnt_q        <= '0;
            cout_final_q <= 1'b0;
            ovf_q        <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            out_sum_q   <= sum_d;
            out_valid_q <= 1'b1;
            carry_q     <= cout_d;
            cnt_q       <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              out_last_q   <= 1'b1;
              cout_final_q <= cout_d;
              ovf_q        <= ovf_d;
              state_q      <= S_DRAIN;
            end
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ADD16_SEQ_ZFLAG_EN
  logic zacc_q;
  logic zero_flag_q;

  // zacc_q accumulates "all words zero" and is published when the last word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      zacc_q      <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        zacc_q      <= 1'b1;
        zero_flag_q <= 1'b0;
      end else if (state_q == S_RUN && in_hs) begin
        zacc_q <= zacc_q && (sum_d == 16'h0000);
      end else if (state_q == S_DRAIN && out_hs) begin
        zero_flag_q <= zacc_q;
      end
    end
  end

  assign zero_flag = zero_flag_q;
`endif

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign cout_final = cout_final_q;
  assign ovf        = ovf_q;
endmodule
